// File: rtl/cluster_soc_evt_fifo_pkg.sv
// Shared types and default sizes for the SoC peripheral event FIFO.
package cluster_soc_evt_fifo_pkg;

   localparam int EVNT_WIDTH             = 8;
   localparam int SOC_EVT_FIFO_DEPTH     = 8;
   localparam int SOC_EVT_DROP_CNT_WIDTH = 16;

   typedef logic [EVNT_WIDTH-1:0] soc_evt_t;

endpackage

// File: rtl/cluster_soc_evt_fifo_if.sv
// Event capture / event-unit handshake bundle for cluster_soc_evt_fifo.
interface cluster_soc_evt_fifo_if #(
   parameter int EVNT_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int CNT_WIDTH  = 16
);

   logic                     flush_i;
   logic                     soc_evt_valid_i;
   logic [EVNT_WIDTH-1:0]    soc_evt_data_i;
   logic                     evt_valid_o;
   logic                     evt_ready_i;
   logic [EVNT_WIDTH-1:0]    evt_data_o;
   logic [$clog2(DEPTH):0]   level_o;
   logic                     overflow_o;
   logic                     clr_overflow_i;
   logic [CNT_WIDTH-1:0]     drop_cnt_o;

   modport slave (
      input  flush_i, soc_evt_valid_i, soc_evt_data_i, evt_ready_i, clr_overflow_i,
      output evt_valid_o, evt_data_o, level_o, overflow_o, drop_cnt_o
   );

   modport master (
      output flush_i, soc_evt_valid_i, soc_evt_data_i, evt_ready_i, clr_overflow_i,
      input  evt_valid_o, evt_data_o, level_o, overflow_o, drop_cnt_o
   );

endinterface

// File: rtl/cluster_soc_evt_fifo_ptr.sv
// Read/write pointers with wrap bit, full/empty detection and occupancy.
module cluster_soc_evt_fifo_ptr
   import cluster_soc_evt_fifo_pkg::*;
#(
   parameter int DEPTH = SOC_EVT_FIFO_DEPTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  i_flush,
   input  logic                  i_push,
   input  logic                  i_pop,
   output logic [$clog2(DEPTH):0] o_wr_ptr,
   output logic [$clog2(DEPTH):0] o_rd_ptr,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [$clog2(DEPTH):0] o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Same index with opposite wrap bits means the writer lapped the reader.
   assign o_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign o_empty  = (r_wr_ptr == r_rd_ptr);
   assign o_level  = r_wr_ptr - r_rd_ptr;
   assign o_wr_ptr = r_wr_ptr;
   assign o_rd_ptr = r_rd_ptr;

endmodule

// File: rtl/cluster_soc_evt_fifo.sv
// SoC peripheral event FIFO with sticky overflow; optional saturating drop
// counter enabled by CLUSTER_SOC_EVT_FIFO_DROP_CNT_EN.
module cluster_soc_evt_fifo
   import cluster_soc_evt_fifo_pkg::*;
#(
   parameter int EVNT_WIDTH = $bits(soc_evt_t),
   parameter int DEPTH      = SOC_EVT_FIFO_DEPTH,
   parameter int CNT_WIDTH  = SOC_EVT_DROP_CNT_WIDTH
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   cluster_soc_evt_fifo_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]           w_wr_ptr;
   logic [AW:0]           w_rd_ptr;
   logic                  w_full;
   logic                  w_empty;
   logic [AW:0]           w_level;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_drop;
   logic [EVNT_WIDTH-1:0] r_mem [DEPTH];
   logic                  r_overflow;

   // A flush overrides both sides of the handshake in its cycle.
   assign w_pop  = !w_empty && bus.evt_ready_i && !bus.flush_i;
   assign w_push = bus.soc_evt_valid_i && !bus.flush_i && (!w_full || w_pop);
   assign w_drop = bus.soc_evt_valid_i && w_full && !w_pop && !bus.flush_i;

   cluster_soc_evt_fifo_ptr #(
      .DEPTH (DEPTH)
   ) u_ptr (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .i_flush  (bus.flush_i),
      .i_push   (w_push),
      .i_pop    (w_pop),
      .o_wr_ptr (w_wr_ptr),
      .o_rd_ptr (w_rd_ptr),
      .o_full   (w_full),
      .o_empty  (w_empty),
      .o_level  (w_level)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[w_wr_ptr[AW-1:0]] <= bus.soc_evt_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                   r_overflow <= 1'b0;
      else if (w_drop)             r_overflow <= 1'b1;
      else if (bus.clr_overflow_i) r_overflow <= 1'b0;
   end

   assign bus.evt_valid_o = !w_empty;
   assign bus.evt_data_o  = r_mem[w_rd_ptr[AW-1:0]];
   assign bus.level_o     = w_level;
   assign bus.overflow_o  = r_overflow;

`ifdef CLUSTER_SOC_EVT_FIFO_DROP_CNT_EN
   logic [CNT_WIDTH-1:0] r_drop_cnt;

   // A drop in the clearing cycle restarts the count at one.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_drop_cnt <= '0;
      end else if (w_drop) begin
         if (bus.clr_overflow_i)  r_drop_cnt <= CNT_WIDTH'(1);
         else if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
      end else if (bus.clr_overflow_i) begin
         r_drop_cnt <= '0;
      end
   end

   assign bus.drop_cnt_o = r_drop_cnt;
`else
   assign bus.drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cluster_soc_evt_fifo.sv
// Directed bench for cluster_soc_evt_fifo; covers both builds of the drop counter.
module tb_cluster_soc_evt_fifo;

`ifdef CLUSTER_SOC_EVT_FIFO_DROP_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   cluster_soc_evt_fifo_if #(.EVNT_WIDTH(8), .DEPTH(8), .CNT_WIDTH(16)) bus ();

   cluster_soc_evt_fifo #(
      .EVNT_WIDTH (8),
      .DEPTH      (8),
      .CNT_WIDTH  (16)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0] exp_q [9];
      n_vec = 0;
      n_err = 0;
      rst                 = 1'b1;
      bus.flush_i         = 1'b0;
      bus.soc_evt_valid_i = 1'b0;
      bus.soc_evt_data_i  = 8'h00;
      bus.evt_ready_i     = 1'b0;
      bus.clr_overflow_i  = 1'b0;

      #2;
      chk("rst_valid",    32'(bus.evt_valid_o), 32'd0);
      chk("rst_data",     32'(bus.evt_data_o),  32'd0);
      chk("rst_level",    32'(bus.level_o),     32'd0);
      chk("rst_overflow", 32'(bus.overflow_o),  32'd0);
      chk("rst_dropcnt",  32'(bus.drop_cnt_o),  32'd0);
      tick();
      rst = 1'b0;

      // single push, one-cycle latency, then pop
      bus.soc_evt_valid_i = 1'b1;
      bus.soc_evt_data_i  = 8'h2A;
      tick();
      bus.soc_evt_valid_i = 1'b0;
      chk("single_valid", 32'(bus.evt_valid_o), 32'd1);
      chk("single_data",  32'(bus.evt_data_o),  32'h2A);
      chk("single_level", 32'(bus.level_o),     32'd1);
      bus.evt_ready_i = 1'b1;
      tick();
      bus.evt_ready_i = 1'b0;
      chk("single_pop_valid", 32'(bus.evt_valid_o), 32'd0);
      chk("single_pop_level", 32'(bus.level_o),     32'd0);

      // fill to DEPTH, then drop one
      for (int i = 1; i <= 8; i++) begin
         bus.soc_evt_valid_i = 1'b1;
         bus.soc_evt_data_i  = 8'(i);
         tick();
      end
      chk("full_level",    32'(bus.level_o),    32'd8);
      chk("full_head",     32'(bus.evt_data_o), 32'h01);
      chk("full_no_ovf",   32'(bus.overflow_o), 32'd0);
      bus.soc_evt_data_i = 8'h09;
      tick();
      bus.soc_evt_valid_i = 1'b0;
      chk("drop_overflow", 32'(bus.overflow_o), 32'd1);
      chk("drop_level",    32'(bus.level_o),    32'd8);
      chk("drop_head",     32'(bus.evt_data_o), 32'h01);
      chk("drop_cnt_1",    32'(bus.drop_cnt_o), CNT_EN ? 32'd1 : 32'd0);

      // clear, then push with simultaneous pop while full
      bus.clr_overflow_i = 1'b1;
      tick();
      bus.clr_overflow_i = 1'b0;
      chk("clr_overflow", 32'(bus.overflow_o), 32'd0);
      chk("clr_dropcnt",  32'(bus.drop_cnt_o), 32'd0);
      chk("pp_head_pre",  32'(bus.evt_data_o), 32'h01);
      bus.evt_ready_i     = 1'b1;
      bus.soc_evt_valid_i = 1'b1;
      bus.soc_evt_data_i  = 8'h55;
      tick();
      bus.soc_evt_valid_i = 1'b0;
      chk("pp_level",    32'(bus.level_o),    32'd8);
      chk("pp_overflow", 32'(bus.overflow_o), 32'd0);
      exp_q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h55, 8'h00};
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain_%0d", i), 32'(bus.evt_data_o), 32'(exp_q[i]));
         tick();
      end
      chk("drain_valid", 32'(bus.evt_valid_o), 32'd0);
      chk("drain_level", 32'(bus.level_o),     32'd0);

      // streaming at one event per cycle across pointer wrap
      for (int i = 0; i < 40; i++) begin
         bus.soc_evt_valid_i = 1'b1;
         bus.soc_evt_data_i  = 8'(i);
         tick();
         chk($sformatf("stream_data_%0d", i), 32'(bus.evt_data_o), 32'(i));
         if (i % 8 == 7) begin
            chk($sformatf("stream_level_%0d", i), 32'(bus.level_o), 32'd1);
         end
      end
      bus.soc_evt_valid_i = 1'b0;
      tick();
      bus.evt_ready_i = 1'b0;
      chk("stream_end_valid", 32'(bus.evt_valid_o), 32'd0);
      chk("stream_end_ovf",   32'(bus.overflow_o),  32'd0);

      // flush at level 5 with a same-cycle push
      for (int i = 0; i < 5; i++) begin
         bus.soc_evt_valid_i = 1'b1;
         bus.soc_evt_data_i  = 8'(8'h10 + i);
         tick();
      end
      chk("pre_flush_level", 32'(bus.level_o), 32'd5);
      bus.flush_i        = 1'b1;
      bus.soc_evt_data_i = 8'h33;
      tick();
      bus.flush_i         = 1'b0;
      bus.soc_evt_valid_i = 1'b0;
      chk("flush_level", 32'(bus.level_o),     32'd0);
      chk("flush_valid", 32'(bus.evt_valid_o), 32'd0);
      chk("flush_ovf",   32'(bus.overflow_o),  32'd0);
      tick();
      chk("flush_no_store", 32'(bus.level_o), 32'd0);

      // refill, saturate the counter (when built), clear racing a drop
      for (int i = 0; i < 8; i++) begin
         bus.soc_evt_valid_i = 1'b1;
         bus.soc_evt_data_i  = 8'(8'h80 + i);
         tick();
      end
      chk("refill_ovf", 32'(bus.overflow_o), 32'd0);
`ifdef CLUSTER_SOC_EVT_FIFO_DROP_CNT_EN
      for (int i = 0; i < 70000; i++) tick();
      chk("sat_cnt", 32'(bus.drop_cnt_o), 32'hFFFF);
      chk("sat_ovf", 32'(bus.overflow_o), 32'd1);
`endif
      bus.clr_overflow_i = 1'b1;
      tick();
      bus.clr_overflow_i  = 1'b0;
      bus.soc_evt_valid_i = 1'b0;
      chk("clr_race_ovf",   32'(bus.overflow_o), 32'd1);
      chk("clr_race_cnt",   32'(bus.drop_cnt_o), CNT_EN ? 32'd1 : 32'd0);
      chk("clr_race_level", 32'(bus.level_o),    32'd8);

      // asynchronous reset mid-burst
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i         = 1'b0;
      bus.soc_evt_valid_i = 1'b1;
      bus.soc_evt_data_i  = 8'h70;
      tick();
      tick();
      chk("burst_level", 32'(bus.level_o), 32'd2);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_valid",   32'(bus.evt_valid_o), 32'd0);
      chk("arst_data",    32'(bus.evt_data_o),  32'd0);
      chk("arst_level",   32'(bus.level_o),     32'd0);
      chk("arst_ovf",     32'(bus.overflow_o),  32'd0);
      chk("arst_dropcnt", 32'(bus.drop_cnt_o),  32'd0);
      bus.soc_evt_valid_i = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_valid", 32'(bus.evt_valid_o), 32'd0);
      chk("post_rst_level", 32'(bus.level_o),     32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
